id_ex_register: RTL and testbench
=================================

# id_ex_register

ID/EX pipeline register for the five-stage MIPS core. It captures the decode-stage bundle at the clock edge and presents it to the execute stage: PC+4, both register-file read values, the 32-bit sign-extended immediate produced by the sign-extend unit, register specifiers and the control word. It contains the load-use hazard detector. On a hazard it inserts a bubble into EX and tells the front end to hold. It also implements the stall and flush controls for the pipeline.

## Interface
Parameters:
- CTRL_W, 8: width of the control word bundle.
- MEMREAD_BIT, 0: bit index of mem_read inside the control word.

Ports (one clock, `clk`; reset `reset` is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- stall  in  1  external hold (e.g. memory wait); freezes this register.
- flush  in  1  squash the instruction entering EX (branch taken / jump).
- id_valid  in  1  decode stage holds a real instruction.
- id_pc_plus4  in  32  PC+4 of the decode instruction.
- id_rd1, id_rd2  in  32 each  register-file read data.
- id_imm_ext  in  32  sign-extended immediate from the sign-extend unit.
- id_rs, id_rt, id_rd  in  5 each  register specifiers.
- id_ctrl  in  CTRL_W  decoded control word.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm_ext  out  32 each  registered copies.
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers.
- ex_ctrl  out  CTRL_W  registered control word.
- hazard_stall  out  1  combinational; front end must hold PC and IF/ID this cycle.

## Operation
- Load-use detect: hazard_stall = ex_valid & ex_ctrl[MEMREAD_BIT] & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- Per rising edge, priority order:
  - flush → bubble.
  - else stall → hold all outputs unchanged.
  - else hazard_stall → bubble.
  - else load all id_* into ex_*; ex_valid ← id_valid.
- Bubble: ex_valid ← 0, ex_ctrl ← 0, all data and specifier outputs ← 0.
- Width rules: every field is copied bit-exact, with no extension or truncation. id_imm_ext is already 32-bit signed.
- A zero control word means no register write, no memory access and no branch.

## Timing
- Reset: asynchronous; every output register is 0 immediately on `reset` high. This includes ex_valid, ex_ctrl and all 32/5-bit fields.
- Reset deasserted mid-operation: the first edge after deassertion loads normally.
- Latency: 1 cycle from id_* to ex_*.
- hazard_stall is combinational from ex_* and id_*, with no extra latency. It deasserts the cycle after the bubble is inserted, because ex_valid is then 0.
- Simultaneous events:
  - flush and stall both high: flush wins, bubble inserted.
  - stall and hazard both high: hold wins; hazard_stall stays asserted.
  - flush and hazard both high: bubble.
- Back-to-back loads to the same rt: exactly one bubble per dependent consumer.

## Configuration
- ID_EX_BUBBLE_CNT_EN defined:
  - Adds output bubble_cnt (out, 32). It increments by 1 on each edge that inserts a bubble, from either flush or hazard.
  - Stall edges do not increment it.
  - It is cleared to 0 by reset and wraps 0xFFFFFFFF→0.
- ID_EX_BUBBLE_CNT_EN undefined: no port, no counter logic.

## Test plan
- Reset: assert reset asynchronously between edges → all ex_* = 0 and ex_valid = 0 immediately, before the next edge.
- Pass-through: id_valid=1, id_imm_ext=0xFFFF8000, id_rd1=0x12345678, id_ctrl=0x5A → next edge ex_imm_ext=0xFFFF8000, ex_rd1=0x12345678, ex_ctrl=0x5A, ex_valid=1.
- Load-use:
  - Setup: ex holds lw with ex_rt=8 and mem_read=1; id_rs=8.
  - hazard_stall=1 → next edge ex_valid=0, ex_ctrl=0.
  - One edge later the dependent instruction loads.
  - Repeat with ex_rt=0 → no hazard.
- Stall hold: outputs loaded; stall=1 for 3 cycles while id_* changes → ex_* unchanged; resumes loading when stall=0.
- Flush priority: flush=1 and stall=1 on the same edge → bubble (ex_valid=0).
- Counter (ID_EX_BUBBLE_CNT_EN):
  - Stimulus: 2 flushes, 1 hazard, 3 stalls → bubble_cnt=3.
  - Wrap: preload 0xFFFFFFFF by forcing, then one flush → bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use hazard detection, stall and flush.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_register #(
    parameter int CTRL_W      = 8,
    parameter int MEMREAD_BIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc_plus4,
    input  logic [31:0]       id_rd1,
    input  logic [31:0]       id_rd2,
    input  logic [31:0]       id_imm_ext,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    output logic [31:0]       ex_pc_plus4,
    output logic [31:0]       ex_rd1,
    output logic [31:0]       ex_rd2,
    output logic [31:0]       ex_imm_ext,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              hazard_stall
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]       bubble_cnt
`endif
);
    logic bubble;
    assign hazard_stall = ex_valid & ex_ctrl[MEMREAD_BIT] & id_valid & (ex_rt != 5'd0) &
                          ((ex_rt == id_rs) | (ex_rt == id_rt));
    // stall holds the register unless flush overrides it; hazard only bubbles when not held
    assign bubble = flush | (~stall & hazard_stall);
    always_ff @(posedge clk or posedge reset) begin
        if (reset || bubble) begin
            ex_valid    <= 1'b0;
            ex_pc_plus4 <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm_ext  <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
        end else if (!stall) begin
            ex_valid    <= id_valid;
            ex_pc_plus4 <= id_pc_plus4;
            ex_rd1      <= id_rd1;
            ex_rd2      <= id_rd2;
            ex_imm_ext  <= id_imm_ext;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_ctrl;
        end
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_cnt <= '0;
        else if (bubble)
            bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: directed vectors with a queue scoreboard for id_ex_register.
module tb_id_ex_register;
    typedef struct packed {
        logic        v;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
    } bun_t;
    typedef struct packed {
        logic hz;
        bun_t e;
    } item_t;
    logic clk = 0, reset = 1, stall = 0, flush = 0;
    bun_t id = '0;
    logic ex_valid, hazard_stall;
    logic [31:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm_ext;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic [7:0] ex_ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif
    item_t q[$];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    id_ex_register dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id.v), .id_pc_plus4(id.pc), .id_rd1(id.rd1), .id_rd2(id.rd2),
        .id_imm_ext(id.imm), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd), .id_ctrl(id.ctrl),
        .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .hazard_stall(hazard_stall)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );
    function automatic bun_t mk(logic v, logic [31:0] pc, rd1, rd2, imm, logic [4:0] rs, rt, rd, logic [7:0] ctrl);
        mk = {v, pc, rd1, rd2, imm, rs, rt, rd, ctrl};
    endfunction
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask
    task automatic step(input logic s, input logic f, input bun_t i, input logic hz, input bun_t e);
        @(negedge clk);
        stall = s;
        flush = f;
        id = i;
        q.push_back('{hz, e});
    endtask
    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                it = q[0];
                chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, it.hz});
                @(posedge clk);
                #1;
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, it.e.v});
                chk("ex_pc_plus4", ex_pc_plus4, it.e.pc);
                chk("ex_rd1", ex_rd1, it.e.rd1);
                chk("ex_rd2", ex_rd2, it.e.rd2);
                chk("ex_imm_ext", ex_imm_ext, it.e.imm);
                chk("ex_rs", {27'd0, ex_rs}, {27'd0, it.e.rs});
                chk("ex_rt", {27'd0, ex_rt}, {27'd0, it.e.rt});
                chk("ex_rd", {27'd0, ex_rd}, {27'd0, it.e.rd});
                chk("ex_ctrl", {24'd0, ex_ctrl}, {24'd0, it.e.ctrl});
                void'(q.pop_front());
            end
        end
    end
    task automatic drain;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask
    initial begin : driver
        bun_t z, a, l, d, l0, d0, l2, d2, l3, n3, b, c, e, f, l4, d4, g, l5, d5;
        z  = '0;
        a  = mk(1, 32'h4,  32'h12345678, 32'h0,      32'hFFFF8000, 5'd1,  5'd2,  5'd3,  8'h5A);
        l  = mk(1, 32'h8,  32'h100,      32'h200,    32'h4,        5'd9,  5'd8,  5'd0,  8'h03);
        d  = mk(1, 32'hC,  32'hAAAA5555, 32'h1,      32'h7FFF,     5'd8,  5'd4,  5'd5,  8'h0C);
        l0 = mk(1, 32'h10, 32'h11,       32'h22,     32'h8,        5'd1,  5'd0,  5'd0,  8'h03);
        d0 = mk(1, 32'h14, 32'h33,       32'h44,     32'hFFFFFFFF, 5'd0,  5'd7,  5'd2,  8'h40);
        l2 = mk(1, 32'h18, 32'h55,       32'h66,     32'hC,        5'd4,  5'd6,  5'd0,  8'h01);
        d2 = mk(1, 32'h1C, 32'h77,       32'h88,     32'h10,       5'd3,  5'd6,  5'd9,  8'h80);
        l3 = mk(1, 32'h20, 32'h99,       32'hAA,     32'h14,       5'd4,  5'd6,  5'd0,  8'h01);
        n3 = mk(0, 32'h24, 32'hBB,       32'hCC,     32'h18,       5'd6,  5'd6,  5'd1,  8'hFF);
        b  = mk(1, 32'h28, 32'hDEADBEEF, 32'hCAFEF00D, 32'h1C,     5'd10, 5'd11, 5'd12, 8'h24);
        c  = mk(1, 32'h2C, 32'h01010101, 32'h02020202, 32'h20,     5'd13, 5'd14, 5'd15, 8'h18);
        e  = mk(1, 32'h30, 32'h03030303, 32'h04040404, 32'h24,     5'd16, 5'd17, 5'd18, 8'h42);
        f  = mk(0, 32'h34, 32'h05050505, 32'h06060606, 32'h28,     5'd19, 5'd20, 5'd21, 8'h81);
        l4 = mk(1, 32'h38, 32'h1,        32'h2,      32'h2C,       5'd2,  5'd10, 5'd0,  8'h07);
        d4 = mk(1, 32'h3C, 32'h3,        32'h4,      32'h30,       5'd10, 5'd1,  5'd3,  8'h50);
        g  = mk(1, 32'h40, 32'h5,        32'h6,      32'h34,       5'd22, 5'd23, 5'd24, 8'h60);
        l5 = mk(1, 32'h44, 32'h7,        32'h8,      32'h38,       5'd5,  5'd31, 5'd0,  8'h03);
        d5 = mk(1, 32'h48, 32'h9,        32'hA,      32'h3C,       5'd0,  5'd31, 5'd4,  8'h30);
        repeat (2) @(negedge clk);
        reset = 0;
        step(0, 0, a,  0, a);
        step(0, 0, l,  0, l);
        step(0, 0, d,  1, z);
        step(0, 0, d,  0, d);
        step(0, 0, l0, 0, l0);
        step(0, 0, d0, 0, d0);
        step(0, 0, l2, 0, l2);
        step(0, 0, d2, 1, z);
        step(0, 0, d2, 0, d2);
        step(0, 0, l3, 0, l3);
        step(0, 0, n3, 0, n3);
        step(0, 0, b,  0, b);
        step(1, 0, c,  0, b);
        step(1, 0, e,  0, b);
        step(1, 0, f,  0, b);
        step(0, 0, c,  0, c);
        step(0, 0, l4, 0, l4);
        step(1, 0, d4, 1, l4);
        step(0, 0, d4, 1, z);
        step(0, 0, d4, 0, d4);
        step(1, 1, g,  0, z);
        step(0, 0, l5, 0, l5);
        step(0, 1, d5, 1, z);
        step(0, 0, a,  0, a);
        drain();
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("bubble_cnt", bubble_cnt, 32'd5);
`endif
        @(negedge clk);
        #1;
        reset = 1;
        #1;
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset ex_rd1", ex_rd1, 32'd0);
        chk("reset ex_imm_ext", ex_imm_ext, 32'd0);
        chk("reset ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
        chk("reset ex_pc_plus4", ex_pc_plus4, 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("reset bubble_cnt", bubble_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 0;
        stall = 0;
        flush = 0;
        id = z;
`ifdef ID_EX_BUBBLE_CNT_EN
        force dut.bubble_cnt = 32'hFFFFFFFF;
        #1;
        release dut.bubble_cnt;
        step(0, 1, a, 0, z);
        drain();
        chk("bubble_cnt wrap", bubble_cnt, 32'd0);
`endif
        step(0, 0, b, 0, b);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
